pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline stage register for the 5-stage core.
- Successor to the fixed-field stage registers; carries a packed control word and a packed data payload with valid/ready handshake.
- Provides flush-to-bubble, optional 2-entry skid buffer (registered in_ready), and a saturating stall-cycle counter for performance monitoring.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

---
 rtl/pipe_stage_reg_pkg.sv | 32 +++
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the core's elastic stage registers: the packed control word
// and the ID/EX payload layout whose width sizes the default data path.
package pipe_stage_reg_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
    logic [2:0] funct3;
    logic [1:0] rsvd;
  } ctrl_signals_t;

  // pc is word aligned, so only pc[31:2] travels down the pipe
  typedef struct packed {
    logic [29:0] pc_word;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [23:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } idex_payload_t;

  localparam int CTRL_SIG_W  = $bits(ctrl_signals_t);
  localparam int IDEX_DATA_W = $bits(idex_payload_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage: optional two-entry skid buffer with a
// flopped in_ready, flush-to-bubble, and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W  = CTRL_SIG_W,
  parameter int DATA_W  = IDEX_DATA_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept;
  logic              take;

  assign take      = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : {CTRL_W{1'b0}};
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  if (SKID_EN) begin : g_skid
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q && !flush;

    // Next-state for the main/skid pair; {main,skid} encodes EMPTY/FULL/SKID
    always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_ctrl_d  = {CTRL_W{1'b0}};
        skid_ctrl_d  = {CTRL_W{1'b0}};
      end else begin
        case ({main_valid_q, skid_valid_q})
          2'b00: begin
            if (accept) begin
              main_valid_d = 1'b1;
              main_ctrl_d  = in_ctrl;
              main_data_d  = in_data;
            end else begin
              main_valid_d = 1'b0;
            end
          end
          2'b10: begin
            if (accept && take) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else if (accept) begin
              skid_valid_d = 1'b1;
              skid_ctrl_d  = in_ctrl;
              skid_data_d  = in_data;
            end else if (take) begin
              main_valid_d = 1'b0;
            end else begin
              main_valid_d = 1'b1;
            end
          end
          2'b11: begin
            if (take) begin
              main_ctrl_d  = skid_ctrl_q;
              main_data_d  = skid_data_q;
              skid_valid_d = 1'b0;
            end else begin
              skid_valid_d = 1'b1;
            end
          end
          default: begin
            // skid without main cannot occur; drop both to resynchronise
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
          end
        endcase
      end
    end

    // Skid entry and the flopped in_ready that mirrors its emptiness
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid_q <= 1'b0;
        skid_ctrl_q  <= {CTRL_W{1'b0}};
        skid_data_q  <= {DATA_W{1'b0}};
        in_ready_q   <= 1'b1;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_ctrl_q  <= skid_ctrl_d;
        skid_data_q  <= skid_data_d;
        in_ready_q   <= !skid_valid_d;
      end
    end
  end else begin : g_single
    assign in_ready = !main_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Single entry: a same-cycle take and accept simply replaces the entry
    always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      if (flush) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = {CTRL_W{1'b0}};
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (take) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end
  end

  // Stall counter: clear wins over increment, and it sticks at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Main entry and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= {CTRL_W{1'b0}};
      main_data_q  <= {DATA_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid-enabled stage (4-bit stall counter) driven from a
// vector table, plus a single-entry stage driven by a short hand sequence.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 133;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // skid-enabled instance
  logic          a_flush = 1'b0, a_iv = 1'b0, a_ordy = 1'b0, a_clr = 1'b0;
  logic [CW-1:0] a_ic = '0;
  logic [DW-1:0] a_id = '0;
  logic          a_ir, a_ov;
  logic [CW-1:0] a_oc;
  logic [DW-1:0] a_od;
  logic [3:0]    a_cnt;

  // single-entry instance
  logic          b_flush = 1'b0, b_iv = 1'b0, b_ordy = 1'b0, b_clr = 1'b0;
  logic [CW-1:0] b_ic = '0;
  logic [DW-1:0] b_id = '0;
  logic          b_ir, b_ov;
  logic [CW-1:0] b_oc;
  logic [DW-1:0] b_od;
  logic [15:0]   b_cnt;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_ctrl(a_ic), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_ordy), .out_ctrl(a_oc), .out_data(a_od),
    .stall_cnt(a_cnt), .clr_cnt(a_clr)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) u_single (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_ic), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_ordy), .out_ctrl(b_oc), .out_data(b_od),
    .stall_cnt(b_cnt), .clr_cnt(b_clr)
  );

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          e_ov;
    logic [CW-1:0] e_oc;
    logic          e_ir;
    logic [3:0]    e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs, then expected out_valid/out_ctrl/in_ready/stall_cnt after the edge
    vec[0] = '{1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b1, 4'd0};
    for (int k = 1; k <= 8; k++)
      vec[k] = '{1'b1, 16'(k), 1'b1, 1'b0, 1'b0, 1'b1, 16'(k), 1'b1, 4'd0};
    vec[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0};
    vec[10] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 4'd0};
    vec[11] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 4'd1};
    vec[12] = '{1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 4'd2};
    vec[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 4'd3};
    vec[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b1, 4'd3};
    vec[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3};
    vec[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd0};
    vec[17] = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0044, 1'b1, 4'd0};
    vec[18] = '{1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0044, 1'b0, 4'd1};
    vec[19] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2};
    vec[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2};
    vec[21] = '{1'b1, 16'h0066, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2};
    vec[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2};

    // reset held with an input offered
    a_iv = 1'b1;
    a_ic = 16'hFFFF;
    a_id = DW'(16'hFFFF);
    repeat (3) tick();
    check("rst out_valid", DW'(a_ov), DW'(1'b0));
    check("rst out_ctrl", DW'(a_oc), DW'(16'h0000));
    check("rst out_data", a_od, {DW{1'b0}});
    check("rst stall_cnt", DW'(a_cnt), DW'(4'd0));
    check("rst in_ready", DW'(a_ir), DW'(1'b1));
    check("rst single in_ready", DW'(b_ir), DW'(1'b1));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      a_iv    = vec[i].iv;
      a_ic    = vec[i].ic;
      a_id    = DW'(vec[i].ic);
      a_ordy  = vec[i].ordy;
      a_flush = vec[i].fl;
      a_clr   = vec[i].clr;
      tick();
      check($sformatf("v%0d out_valid", i), DW'(a_ov), DW'(vec[i].e_ov));
      check($sformatf("v%0d out_ctrl", i), DW'(a_oc), DW'(vec[i].e_oc));
      check($sformatf("v%0d in_ready", i), DW'(a_ir), DW'(vec[i].e_ir));
      check($sformatf("v%0d stall_cnt", i), DW'(a_cnt), DW'(vec[i].e_cnt));
      if (vec[i].e_ov)
        check($sformatf("v%0d out_data", i), a_od, DW'(vec[i].e_oc));
    end

    // saturation of the 4-bit counter, then clear while still stalled
    a_iv = 1'b1; a_ic = 16'h0077; a_id = DW'(16'h0077);
    a_ordy = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
    tick();
    a_iv = 1'b0;
    repeat (20) tick();
    check("sat stall_cnt", DW'(a_cnt), DW'(4'd15));
    check("sat out_ctrl", DW'(a_oc), DW'(16'h0077));
    a_clr = 1'b1;
    tick();
    check("clr stall_cnt", DW'(a_cnt), DW'(4'd0));
    a_clr = 1'b0;
    tick();
    check("post clr stall_cnt", DW'(a_cnt), DW'(4'd1));
    a_ordy = 1'b1;
    tick();
    check("drain out_valid", DW'(a_ov), DW'(1'b0));

    // single-entry stage: stall blocks input, same-cycle take replaces entry
    b_iv = 1'b1; b_ic = 16'h0C01; b_id = DW'(16'h0C01); b_ordy = 1'b0;
    tick();
    check("single first out_ctrl", DW'(b_oc), DW'(16'h0C01));
    b_ic = 16'h0C02; b_id = DW'(16'h0C02);
    #1;
    check("single stalled in_ready", DW'(b_ir), DW'(1'b0));
    tick();
    check("single hold out_ctrl", DW'(b_oc), DW'(16'h0C01));
    check("single stall_cnt", DW'(b_cnt), DW'(16'd1));
    b_ordy = 1'b1;
    #1;
    check("single take in_ready", DW'(b_ir), DW'(1'b1));
    tick();
    check("single replace out_ctrl", DW'(b_oc), DW'(16'h0C02));
    check("single replace out_data", b_od, DW'(16'h0C02));
    b_ic = 16'h0C03; b_id = DW'(16'h0C03);
    tick();
    check("single stream3", DW'(b_oc), DW'(16'h0C03));
    b_ic = 16'h0C04; b_id = DW'(16'h0C04);
    tick();
    check("single stream4", DW'(b_oc), DW'(16'h0C04));
    check("single stall_cnt held", DW'(b_cnt), DW'(16'd1));
    b_iv = 1'b0;
    tick();
    check("single empty out_valid", DW'(b_ov), DW'(1'b0));
    check("single empty out_ctrl", DW'(b_oc), DW'(16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
